// File: rtl/tpu_host_pkg.sv
// Shared types and constants for the TPU host driver: FSM state encoding,
// transfer lengths, uio bit positions and the matrix element placement helper.
package tpu_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        READ,
        FINISH
    } state_t;

    localparam int LOAD_BYTES = 8;
    localparam int READ_BYTES = 8;

    localparam int LOAD_VALID_BIT = 0;
    localparam int LOAD_INDEX_LSB = 1;
    localparam int READ_REQ_BIT   = 4;
    localparam int DONE_BIT       = 7;

    // Packed slot of element idx (row order a00,a01,a10,a11); column-major swaps the off-diagonals.
    function automatic int elem_pos(input int idx, input bit row_major);
        if (row_major) return idx;
        case (idx)
            1:       return 2;
            2:       return 1;
            default: return idx;
        endcase
    endfunction

endpackage

// File: rtl/tpu_host_if.sv
// Host-side request/result signals and TPU pin bundle for the TPU host driver.
// master = host plus TPU environment, slave = the driver.
interface tpu_host_if;
    logic        start;
    logic [31:0] a_flat;
    logic [31:0] b_flat;
    logic [63:0] c_flat;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  tpu_ui_in;
    logic [7:0]  tpu_uio_in;
    logic [7:0]  tpu_uo_out;
    logic [7:0]  tpu_uio_out;

    modport master (
        output start, a_flat, b_flat, tpu_uo_out, tpu_uio_out,
        input  c_flat, busy, done, err, tpu_ui_in, tpu_uio_in
    );

    modport slave (
        input  start, a_flat, b_flat, tpu_uo_out, tpu_uio_out,
        output c_flat, busy, done, err, tpu_ui_in, tpu_uio_in
    );
endinterface

// File: rtl/tpu_host_readback.sv
// Captures the eight result bytes returned by the TPU and assembles them into
// c_flat on the final byte; c_flat holds until the next completed readback.
module tpu_host_readback
    import tpu_host_pkg::*;
#(
    parameter bit ROW_MAJOR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        last,
    input  logic [7:0]  data,
    output logic [63:0] c_flat
);
    logic [55:0] shreg;
    logic [63:0] bytes_all;
    logic [63:0] c_next;

    // Bytes arrive c00 lo first, so shifting right leaves byte k at bits 8k.
    always_comb begin
        c_next    = '0;
        bytes_all = {data, shreg};
        for (int e = 0; e < 4; e++) begin
            c_next[16*elem_pos(e, ROW_MAJOR) +: 16] = bytes_all[16*e +: 16];
        end
    end

    // NOTE: the shift register is reset along with c_flat so a reset never leaves X in the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            c_flat <= '0;
        end else if (capture) begin
            if (last) c_flat <= c_next;
            else      shreg  <= {data, shreg[55:8]};
        end
    end

endmodule

// File: rtl/tpu_host_driver.sv
// Drives one 2x2 int8 multiply through the TPU byte interface: load A/B, wait for
// compute_done, read back C. Optional WAIT timeout enabled by TPU_HOST_TIMEOUT_EN.
module tpu_host_driver
    import tpu_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit ROW_MAJOR      = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    tpu_host_if.slave bus
);
    localparam logic [3:0] LOAD_LAST = 4'(LOAD_BYTES - 1);
    localparam logic [3:0] READ_LAST = 4'(READ_BYTES);

    state_t      state, state_nx;
    logic [3:0]  byte_cnt;
    logic [63:0] load_buf;
    logic [63:0] load_next;
    logic        comp_seen;
    logic        tmo_hit;
    logic        rb_capture;
    logic        rb_last;
    logic [63:0] c_flat_w;

`ifdef TPU_HOST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // A compute_done already sampled wins over a timeout in the same cycle.
    assign tmo_hit = (state == WAIT) && !comp_seen && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT && state_nx == WAIT) ? tmo_cnt + TMO_W'(1) : '0;
            err_q   <= tmo_hit;
        end
    end

    assign bus.err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign bus.err = 1'b0;
`endif

    // Operands are reordered once at acceptance into wire order a00,a01,a10,a11,b00..b11.
    always_comb begin
        load_next = '0;
        for (int i = 0; i < 4; i++) begin
            load_next[8*i +: 8]      = bus.a_flat[8*elem_pos(i, ROW_MAJOR) +: 8];
            load_next[32 + 8*i +: 8] = bus.b_flat[8*elem_pos(i, ROW_MAJOR) +: 8];
        end
    end

    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            load_buf  <= '0;
            comp_seen <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state)                 byte_cnt <= '0;
            else if (state == LOAD || state == READ) byte_cnt <= byte_cnt + 4'd1;
            if (state == IDLE && bus.start) load_buf <= load_next;
            comp_seen <= (state == WAIT) && bus.tpu_uio_out[DONE_BIT];
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nx       = state;
        bus.tpu_ui_in  = 8'h00;
        bus.tpu_uio_in = 8'h00;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = LOAD;
            end
            LOAD: begin
                bus.tpu_ui_in                         = load_buf[{byte_cnt[2:0], 3'b000} +: 8];
                bus.tpu_uio_in[LOAD_VALID_BIT]        = 1'b1;
                bus.tpu_uio_in[LOAD_INDEX_LSB +: 3]   = byte_cnt[2:0];
                if (byte_cnt == LOAD_LAST) state_nx = WAIT;
            end
            WAIT: begin
                if (comp_seen)    state_nx = READ;
                else if (tmo_hit) state_nx = IDLE;
            end
            READ: begin
                // Last READ cycle only collects the final byte; no request is issued.
                bus.tpu_uio_in[READ_REQ_BIT] = (byte_cnt < READ_LAST);
                if (byte_cnt == READ_LAST) state_nx = FINISH;
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == FINISH);

    assign rb_capture = (state == READ) && (byte_cnt != 4'd0);
    assign rb_last    = (byte_cnt == READ_LAST);

    tpu_host_readback #(
        .ROW_MAJOR (ROW_MAJOR)
    ) u_readback (
        .clk     (clk),
        .rst     (rst),
        .capture (rb_capture),
        .last    (rb_last),
        .data    (bus.tpu_uo_out),
        .c_flat  (c_flat_w)
    );

    assign bus.c_flat = c_flat_w;

endmodule

// File: doc/tpu_host_driver.md
TPU_HOST_DRIVER -- requirements
Module: tpu_host_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max cycles spent in WAIT before error.
REQ-002 SHALL have parameter ROW_MAJOR, default 1, meaning matrices are packed row-major (element 0 at LSBs).
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 start  in  1  one-cycle request to run one 2x2 multiply.
REQ-006 a_flat  in  32  matrix A, four signed 8-bit elements a00,a01,a10,a11.
REQ-007 b_flat  in  32  matrix B, same packing.
REQ-008 c_flat  out  64  result C, four signed 16-bit elements c00,c01,c10,c11.
REQ-009 busy  out  1  high from start acceptance until the done cycle.
REQ-010 done  out  1  one-cycle pulse when c_flat is valid.
REQ-011 err  out  1  one-cycle pulse on WAIT timeout.
REQ-012 tpu_ui_in  out  8  data byte driven to the TPU dedicated inputs.
REQ-013 tpu_uio_in  out  8  control to the TPU: [0] load_valid, [3:1] load_index, [4] read_req, others 0.
REQ-014 tpu_uo_out  in  8  result byte from the TPU.
REQ-015 tpu_uio_out  in  8  TPU status: [7] compute_done.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WAIT, READ, FINISH.
REQ-017 IDLE: start=1 SHALL latch a_flat/b_flat, set busy, go to LOAD next cycle; start outside IDLE SHALL be ignored.
REQ-018 LOAD: SHALL drive 8 consecutive cycles with load_valid=1, load_index=0..7, tpu_ui_in = a00,a01,a10,a11,b00,b01,b10,b11; then WAIT.
REQ-019 WAIT: all control bits 0; SHALL go to READ in the cycle after tpu_uio_out[7] is sampled high.
REQ-020 READ: SHALL assert read_req for 8 cycles; byte k returned on tpu_uo_out one cycle after request k; bytes SHALL be stored as c00 lo, c00 hi, c01 lo, ... c11 hi; READ lasts 9 cycles total.
REQ-021 FINISH: SHALL pulse done for one cycle with c_flat updated in that same cycle, clear busy, return to IDLE.
REQ-022 c_flat SHALL hold its last value until the next FINISH; the driver SHALL not alter byte contents (transport only).
REQ-023 Latency start->done SHALL be 8 + W + 1 + 9 + 1 cycles, W = WAIT cycles until compute_done sampled.
REQ-024 compute_done high outside WAIT SHALL be ignored.
REQ-025 start asserted in the FINISH cycle SHALL be ignored; start in the cycle after done SHALL be accepted.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, err=0, c_flat=0, tpu_ui_in=0, tpu_uio_in=0, timeout counter=0.
REQ-027 Reset mid-operation SHALL abandon the transfer; no done or err pulse SHALL follow.

Configuration
REQ-028 Macro TPU_HOST_TIMEOUT_EN defined: counter runs in WAIT; reaching TIMEOUT_CYCLES without compute_done SHALL pulse err, clear busy, return to IDLE, leave c_flat unchanged.
REQ-029 Macro undefined: no counter logic; WAIT is unbounded; err SHALL be tied 0.

Structure
REQ-030 Shared package tpu_host_pkg SHALL hold the FSM state enum, LOAD_BYTES=8, READ_BYTES=8, and uio bit-position constants (LOAD_VALID_BIT, READ_REQ_BIT, DONE_BIT).
REQ-031 One sub-module tpu_host_readback SHALL implement the 8-byte capture shift register and c_flat assembly.

Verification
REQ-032 A=[1,2;3,4], B=[5,6;7,8], TPU model raises done after 5 cycles -> load bytes 01,02,03,04,05,06,07,08 at indices 0..7; c_flat = {50,43,22,19} as 16-bit; done after 24 cycles.
REQ-033 A=[-1,0;0,-1], B=[127,-128;3,4] -> c_flat elements -127,128,-3,-4 (0xFF81,0x0080,0xFFFD,0xFFFC).
REQ-034 With TPU_HOST_TIMEOUT_EN, model never raises done -> err pulse exactly 64 cycles after WAIT entry, busy=0, c_flat unchanged; without macro busy stays 1.
REQ-035 rst asserted during LOAD index 3 -> all outputs 0 immediately; no done; next start runs full sequence from index 0.
REQ-036 start pulsed during WAIT and during FINISH -> ignored; exactly one done per accepted start.
